// File: rtl/fact_ctrl.sv
// fact_ctrl: Moore control FSM sequencing the factorial datapath.
// Inputs : clk, rst (sync, active high), go (start), n_gt_max (n > 12),
//          cnt_gt_1 (down-counter > 1).
// Outputs: cnt_ld, cnt_en, reg_sel, reg_ld, out_en (datapath strobes),
//          busy (not IDLE), done / err (sticky, registered).
module fact_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic n_gt_max,
  input  logic cnt_gt_1,
  output logic cnt_ld,
  output logic cnt_en,
  output logic reg_sel,
  output logic reg_ld,
  output logic out_en,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [2:0] {IDLE, CHECK, INIT, TEST, MUL, DONE, ERR} state_t;
  localparam logic [3:0] LAST = 4'(MUL_LAT - 1);
  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic done_q, done_d, err_q, err_d;
  logic mul_last;
  assign mul_last = wait_q == LAST;
  always_comb begin
    state_d = IDLE;
    wait_d  = wait_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_ld  = 1'b0;
    cnt_en  = 1'b0;
    reg_sel = 1'b0;
    reg_ld  = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = go ? CHECK : IDLE;
        done_d  = go ? 1'b0 : done_q;
        err_d   = go ? 1'b0 : err_q;
      end
      CHECK: state_d = n_gt_max ? ERR : INIT;
      INIT: begin
        cnt_ld  = 1'b1;
        reg_sel = 1'b1;
        reg_ld  = 1'b1;
        state_d = TEST;
      end
      TEST: begin
        wait_d  = '0;
        state_d = cnt_gt_1 ? MUL : DONE;
      end
      // Product capture and decrement happen together on the last wait cycle.
      MUL: begin
        wait_d  = wait_q + 4'd1;
        reg_ld  = mul_last;
        cnt_en  = mul_last;
        state_d = mul_last ? TEST : MUL;
      end
      DONE: begin
        out_en = 1'b1;
        done_d = 1'b1;
      end
      ERR: err_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err  = err_q;
endmodule
